// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the memory port arbiter.
package mem_arb_pkg;

    // Arbiter FSM states: idle, fetch in flight, data access in flight.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_e;

    localparam int ADDR_W_DEF     = 64;
    localparam int DATA_W_DEF     = 64;
    localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating counter of data grants made while an instruction fetch waits.
module arb_starve_cnt #(
    parameter int MAX = 4,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] MAX_C = W'(MAX);

    logic [W-1:0] cnt_r;

    // Clear wins over increment; increment stops at MAX.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (inc && (cnt_r < MAX_C)) begin
            cnt_r <= cnt_r + W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port (instruction / data) arbiter in front of a single memory port.
// Data requests normally win; an instruction request is guaranteed a grant
// after STARVE_MAX consecutive data grants made while it was waiting.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_we,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              sel,
    output logic              i_done,
    output logic              d_done,
    output logic [DATA_W-1:0] rdata
);

    localparam int              CNT_W        = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX_C = CNT_W'(STARVE_MAX);

    arb_state_e        state_r, next_state_s;
    logic              grant_i_s, grant_d_s;
    logic              complete_i_s, complete_d_s;
    logic [CNT_W-1:0]  starve_cnt_s;

    logic [ADDR_W-1:0] addr_r;
    logic              we_r;
    logic [DATA_W-1:0] wdata_r;
    logic              sel_r;
    logic              mem_req_r;
    logic              i_done_r, d_done_r;
    logic [DATA_W-1:0] rdata_r;

    arb_starve_cnt #(
        .MAX (STARVE_MAX),
        .W   (CNT_W)
    ) u_starve (
        .clk   (clk),
        .reset (reset),
        .inc   (grant_d_s & i_req),
        .clr   (grant_i_s),
        .cnt   (starve_cnt_s)
    );

    // Next-state, grant decision and completion detection.
    always_comb begin
        next_state_s = state_r;
        grant_i_s    = 1'b0;
        grant_d_s    = 1'b0;
        complete_i_s = 1'b0;
        complete_d_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (d_req && (!i_req || (starve_cnt_s < STARVE_MAX_C))) begin
                    grant_d_s    = 1'b1;
                    next_state_s = BUSY_D;
                end else if (i_req) begin
                    grant_i_s    = 1'b1;
                    next_state_s = BUSY_I;
                end else begin
                    next_state_s = IDLE;
                end
            end
            BUSY_I: begin
                if (mem_ready) begin
                    complete_i_s = 1'b1;
                    next_state_s = IDLE;
                end else begin
                    next_state_s = BUSY_I;
                end
            end
            BUSY_D: begin
                if (mem_ready) begin
                    complete_d_s = 1'b1;
                    next_state_s = IDLE;
                end else begin
                    next_state_s = BUSY_D;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State register plus the winner's latched request and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            addr_r    <= '0;
            we_r      <= 1'b0;
            wdata_r   <= '0;
            sel_r     <= 1'b0;
            mem_req_r <= 1'b0;
            i_done_r  <= 1'b0;
            d_done_r  <= 1'b0;
            rdata_r   <= '0;
        end else begin
            state_r  <= next_state_s;
            i_done_r <= complete_i_s;
            d_done_r <= complete_d_s;
            if (grant_d_s) begin
                addr_r    <= d_addr;
                we_r      <= d_we;
                wdata_r   <= d_wdata;
                sel_r     <= 1'b1;
                mem_req_r <= 1'b1;
            end else if (grant_i_s) begin
                addr_r    <= i_addr;
                we_r      <= 1'b0;
                wdata_r   <= '0;
                sel_r     <= 1'b0;
                mem_req_r <= 1'b1;
            end else if (complete_i_s || complete_d_s) begin
                mem_req_r <= 1'b0;
            end else begin
                mem_req_r <= mem_req_r;
            end
            if (complete_i_s || complete_d_s) begin
                rdata_r <= mem_rdata;
            end else begin
                rdata_r <= rdata_r;
            end
        end
    end

    assign mem_req   = mem_req_r;
    assign mem_addr  = addr_r;
    assign mem_we    = we_r;
    assign mem_wdata = wdata_r;
    assign sel       = sel_r;
    assign i_done    = i_done_r;
    assign d_done    = d_done_r;
    assign rdata     = rdata_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (default parameters).
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req;
    logic [63:0] i_addr;
    logic        d_req;
    logic [63:0] d_addr;
    logic        d_we;
    logic [63:0] d_wdata;
    logic        mem_ready;
    logic [63:0] mem_rdata;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_we;
    logic [63:0] mem_wdata;
    logic        sel;
    logic        i_done;
    logic        d_done;
    logic [63:0] rdata;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .d_req     (d_req),
        .d_addr    (d_addr),
        .d_we      (d_we),
        .d_wdata   (d_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .sel       (sel),
        .i_done    (i_done),
        .d_done    (d_done),
        .rdata     (rdata)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b0;
        i_req     = 1'b0;
        i_addr    = 64'h0;
        d_req     = 1'b0;
        d_addr    = 64'h0;
        d_we      = 1'b0;
        d_wdata   = 64'h0;
        mem_ready = 1'b0;
        mem_rdata = 64'h0;

        // Asynchronous reset: outputs clear before any clock edge.
        #2 reset = 1'b1;
        #1;
        chk("rst_mem_req", {63'd0, mem_req}, 64'd0);
        chk("rst_sel",     {63'd0, sel},     64'd0);
        chk("rst_i_done",  {63'd0, i_done},  64'd0);
        chk("rst_d_done",  {63'd0, d_done},  64'd0);
        chk("rst_mem_we",  {63'd0, mem_we},  64'd0);
        chk("rst_addr",    mem_addr,         64'd0);
        chk("rst_wdata",   mem_wdata,        64'd0);
        chk("rst_rdata",   rdata,            64'd0);
        step();
        step();
        reset = 1'b0;

        // Single fetch, minimum latency.
        i_req = 1'b1; i_addr = 64'h100; mem_ready = 1'b1; mem_rdata = 64'hDEAD;
        step();
        chk("f_mem_req", {63'd0, mem_req}, 64'd1);
        chk("f_sel",     {63'd0, sel},     64'd0);
        chk("f_addr",    mem_addr,         64'h100);
        chk("f_we",      {63'd0, mem_we},  64'd0);
        chk("f_idone_early", {63'd0, i_done}, 64'd0);
        step();
        chk("f_idone",   {63'd0, i_done},  64'd1);
        chk("f_rdata",   rdata,            64'hDEAD);
        chk("f_req_off", {63'd0, mem_req}, 64'd0);
        i_req = 1'b0; mem_rdata = 64'h5555;

        // mem_ready while idle is ignored.
        step();
        chk("idle_idone", {63'd0, i_done}, 64'd0);
        chk("idle_ddone", {63'd0, d_done}, 64'd0);
        chk("idle_rdata", rdata,           64'hDEAD);

        // Simultaneous requests: data first, then fetch; data waits 5 cycles.
        mem_ready = 1'b0;
        i_req = 1'b1; i_addr = 64'h300;
        d_req = 1'b1; d_addr = 64'h200; d_we = 1'b1; d_wdata = 64'hAB;
        step();
        d_addr = 64'h999; d_we = 1'b0; d_wdata = 64'h77;
        for (int c = 0; c < 5; c++) begin
            chk("d_sel",   {63'd0, sel},     64'd1);
            chk("d_addr",  mem_addr,         64'h200);
            chk("d_we",    {63'd0, mem_we},  64'd1);
            chk("d_wdata", mem_wdata,        64'hAB);
            chk("d_done_wait", {63'd0, d_done}, 64'd0);
            if (c < 4) step();
        end
        mem_ready = 1'b1; mem_rdata = 64'hBEEF;
        step();
        chk("d_done",    {63'd0, d_done},  64'd1);
        chk("d_i_done",  {63'd0, i_done},  64'd0);
        chk("d_rdata",   rdata,            64'hBEEF);
        chk("d_gap",     {63'd0, mem_req}, 64'd0);
        d_req = 1'b0;
        step();
        chk("i2_sel",  {63'd0, sel},    64'd0);
        chk("i2_addr", mem_addr,        64'h300);
        chk("i2_we",   {63'd0, mem_we}, 64'd0);
        step();
        chk("i2_done", {63'd0, i_done}, 64'd1);

        // Both requests held: D,D,D,D,I repeating.
        d_req = 1'b1; d_addr = 64'h400; d_we = 1'b0;
        for (int g = 0; g < 10; g++) begin
            step();
            chk("st_req", {63'd0, mem_req}, 64'd1);
            chk("st_sel", {63'd0, sel}, (g % 5 == 4) ? 64'd0 : 64'd1);
            step();
            chk("st_ddone", {63'd0, d_done}, (g % 5 == 4) ? 64'd0 : 64'd1);
            chk("st_idone", {63'd0, i_done}, (g % 5 == 4) ? 64'd1 : 64'd0);
        end
        i_req = 1'b0; d_req = 1'b0;
        step();

        // Request dropped mid-access still completes.
        d_req = 1'b1; d_addr = 64'h500; mem_ready = 1'b0;
        step();
        d_req = 1'b0;
        step();
        chk("ab_busy", {63'd0, mem_req}, 64'd1);
        mem_ready = 1'b1; mem_rdata = 64'h1234;
        step();
        chk("ab_done",  {63'd0, d_done}, 64'd1);
        chk("ab_rdata", rdata,           64'h1234);
        step();

        // Reset in the middle of a fetch.
        i_req = 1'b1; i_addr = 64'h140; mem_ready = 1'b0;
        step();
        chk("rb_busy", {63'd0, mem_req}, 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("rb_req",   {63'd0, mem_req}, 64'd0);
        chk("rb_addr",  mem_addr,         64'd0);
        chk("rb_rdata", rdata,            64'd0);
        mem_ready = 1'b1;
        step();
        chk("rb_idone", {63'd0, i_done}, 64'd0);
        reset = 1'b0;
        step();
        chk("rb_regrant", {63'd0, mem_req}, 64'd1);
        chk("rb_addr2",   mem_addr,         64'h140);
        step();
        chk("rb_done",    {63'd0, i_done},  64'd1);
        i_req = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
